// File: rtl/enc_spi_ctrl.sv
// SPI-slave controller: coherent snapshot readout and preset load of the qdec counters.
// Build option ENC_SPI_CHECK_EN appends an XOR check frame (hi ^ lo) to reads and writes.
//   state  | meaning
//   IDLE   | SSEL high or not yet seen falling; SCK ignored
//   CMD    | status word out, command word in
//   RD_HI  | snapshot[ch][31:16] out
//   RD_LO  | snapshot[ch][15:0] out
//   RD_CHK | hi ^ lo out (ENC_SPI_CHECK_EN)
//   WR_HI  | preset high half in
//   WR_LO  | preset low half in
//   WR_CHK | check word in, load on match (ENC_SPI_CHECK_EN)
//   DONE   | transaction complete, wait for SSEL high
//   ERR    | invalid channel, wait for SSEL high
module enc_spi_ctrl #(
  parameter int NCH = 3,
  parameter int CW  = 32
) (
  input  logic              osc,
  input  logic              rst_n,
  input  logic              SCK,
  input  logic              SSEL,
  input  logic              MOSI,
  output logic              MISO,
  input  logic [NCH*CW-1:0] pos_flat,
  output logic [CW-1:0]     preset_val,
  output logic [NCH-1:0]    preset_ld,
  output logic              busy,
  output logic              err_flag
);

  typedef enum logic [3:0] {
    IDLE, CMD, RD_HI, RD_LO, WR_HI, WR_LO,
`ifdef ENC_SPI_CHECK_EN
    RD_CHK, WR_CHK,
`endif
    DONE, ERR
  } state_t;

  state_t        state;
  logic [2:0]    sck_s;
  logic [2:0]    ssel_s;
  logic [1:0]    mosi_s;
  logic [3:0]    bitcnt;
  logic [15:0]   tx_sh;
  logic [14:0]   rx_sh;
  logic [15:0]   wr_hi;
`ifdef ENC_SPI_CHECK_EN
  logic [15:0]   wr_lo;
`endif
  logic [1:0]    ch;
  logic [CW-1:0] snap [NCH];

  logic        sck_rise, sck_fall, ssel_rise, ssel_fall;
  logic        active, ch_ok;
  logic [15:0] rx_word, status_w;

  assign sck_rise  = sck_s[1] & ~sck_s[2];
  assign sck_fall  = ~sck_s[1] & sck_s[2];
  assign ssel_rise = ssel_s[1] & ~ssel_s[2];
  assign ssel_fall = ~ssel_s[1] & ssel_s[2];
  assign active    = (state != IDLE) && (state != DONE) && (state != ERR);
  assign rx_word   = {rx_sh, mosi_s[1]};
  assign ch_ok     = int'(rx_word[1:0]) < NCH;
  assign status_w  = 16'hE300 | {15'd0, err_flag};

  // ssel_s resets low so a select already asserted across reset release is not taken as a new frame
  always_ff @(posedge osc or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sck_s      <= '0;
      ssel_s     <= '0;
      mosi_s     <= '0;
      bitcnt     <= '0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      wr_hi      <= '0;
`ifdef ENC_SPI_CHECK_EN
      wr_lo      <= '0;
`endif
      ch         <= '0;
      MISO       <= 1'b0;
      preset_val <= '0;
      preset_ld  <= '0;
      busy       <= 1'b0;
      err_flag   <= 1'b0;
      for (int i = 0; i < NCH; i++) snap[i] <= '0;
    end else begin
      sck_s     <= {sck_s[1:0], SCK};
      ssel_s    <= {ssel_s[1:0], SSEL};
      mosi_s    <= {mosi_s[0], MOSI};
      preset_ld <= '0;
      if (ssel_fall) begin
        for (int i = 0; i < NCH; i++) snap[i] <= pos_flat[i*CW +: CW];
        MISO   <= status_w[15];
        tx_sh  <= {status_w[14:0], 1'b0};
        bitcnt <= '0;
        busy   <= 1'b1;
        state  <= CMD;
      end else if (ssel_rise) begin
        if (active && bitcnt != 4'd0) err_flag <= 1'b1;
        MISO   <= 1'b0;
        bitcnt <= '0;
        busy   <= 1'b0;
        state  <= IDLE;
      end else if (sck_rise && active) begin
        bitcnt <= bitcnt + 4'd1;
        rx_sh  <= rx_word[14:0];
        if (bitcnt == 4'd15) begin
          case (state)
            CMD: begin
              if (!ch_ok) begin
                err_flag <= 1'b1;
                tx_sh    <= '0;
                state    <= ERR;
              end else begin
                err_flag <= 1'b0;
                ch       <= rx_word[1:0];
                if (rx_word[15]) begin
                  tx_sh <= '0;
                  state <= WR_HI;
                end else begin
                  tx_sh <= snap[rx_word[1:0]][31:16];
                  state <= RD_HI;
                end
              end
            end
            RD_HI: begin
              tx_sh <= snap[ch][15:0];
              state <= RD_LO;
            end
`ifdef ENC_SPI_CHECK_EN
            RD_LO: begin
              tx_sh <= snap[ch][31:16] ^ snap[ch][15:0];
              state <= RD_CHK;
            end
            RD_CHK: begin
              tx_sh <= '0;
              state <= DONE;
            end
`else
            RD_LO: begin
              tx_sh <= '0;
              state <= DONE;
            end
`endif
            WR_HI: begin
              wr_hi <= rx_word;
              state <= WR_LO;
            end
`ifdef ENC_SPI_CHECK_EN
            WR_LO: begin
              wr_lo <= rx_word;
              state <= WR_CHK;
            end
            WR_CHK: begin
              if (rx_word == (wr_hi ^ wr_lo)) begin
                preset_val <= {wr_hi, wr_lo};
                preset_ld  <= NCH'(1) << ch;
              end else begin
                err_flag <= 1'b1;
              end
              state <= DONE;
            end
`else
            WR_LO: begin
              preset_val <= {wr_hi, rx_word};
              preset_ld  <= NCH'(1) << ch;
              state      <= DONE;
            end
`endif
            default: state <= DONE;
          endcase
        end
      end else if (sck_fall) begin
        if (active) begin
          MISO  <= tx_sh[15];
          tx_sh <= {tx_sh[14:0], 1'b0};
        end else begin
          MISO <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_enc_spi_ctrl.sv
// Randomized bench for enc_spi_ctrl: a bit-banged SPI master against a transaction-level model.
module tb_enc_spi_ctrl;
  localparam int NCH = 3;
  localparam int CW  = 32;

  logic              osc = 1'b0;
  logic              rst_n = 1'b0;
  logic              SCK = 1'b0;
  logic              SSEL = 1'b1;
  logic              MOSI = 1'b0;
  logic              MISO;
  logic [NCH*CW-1:0] pos_flat = '0;
  logic [CW-1:0]     preset_val;
  logic [NCH-1:0]    preset_ld;
  logic              busy;
  logic              err_flag;

  int n_checks = 0;
  int n_errors = 0;

  int             ld_cycles = 0;
  int             ld_bad = 0;
  logic [NCH-1:0] ld_seen = '0;
  logic [CW-1:0]  ld_val = '0;

  bit          mdl_err = 1'b0;
  logic [31:0] mdl_val = '0;

  enc_spi_ctrl #(.NCH(NCH), .CW(CW)) dut (
    .osc(osc), .rst_n(rst_n), .SCK(SCK), .SSEL(SSEL), .MOSI(MOSI), .MISO(MISO),
    .pos_flat(pos_flat), .preset_val(preset_val), .preset_ld(preset_ld),
    .busy(busy), .err_flag(err_flag)
  );

  always #5 osc = ~osc;

  always @(negedge osc) begin
    if (preset_ld != '0) begin
      ld_cycles++;
      ld_seen = preset_ld;
      ld_val  = preset_val;
      if (!$onehot(preset_ld)) ld_bad++;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic half_bit();
    repeat (6) @(negedge osc);
  endtask

  task automatic xfer16(input logic [15:0] tx, input int nbits, output logic [15:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      MOSI = tx[15-i];
      half_bit();
      rx[15-i] = MISO;
      SCK = 1'b1;
      half_bit();
      SCK = 1'b0;
    end
  endtask

  task automatic sel_begin();
    SSEL = 1'b0;
    half_bit();
    half_bit();
  endtask

  task automatic sel_end();
    half_bit();
    SSEL = 1'b1;
    half_bit();
    half_bit();
  endtask

  // One complete transaction; expectations come from the command rules, not from DUT state.
  task automatic do_txn(input logic [15:0] cmd, input logic [31:0] wdata,
                        input logic [15:0] chk_word, input logic [NCH*CW-1:0] pos_new);
    logic [31:0] snap_v;
    logic [15:0] rx;
    logic [1:0]  ch;
    int          ld0;
    bit          exp_ld;
    ch     = cmd[1:0];
    snap_v = '0;
    if (int'(ch) < NCH) snap_v = pos_flat[ch*CW +: CW];
    ld0    = ld_cycles;
    exp_ld = 1'b0;
    sel_begin();
    pos_flat = pos_new;
    check_val("busy_hi", 32'(busy), 32'd1);
    xfer16(cmd, 16, rx);
    check_val("status", 32'(rx), 32'(16'hE300 | {15'd0, mdl_err}));
    if (int'(ch) >= NCH) begin
      mdl_err = 1'b1;
      xfer16(wdata[31:16], 16, rx);
      check_val("err_miso0", 32'(rx), 32'd0);
      xfer16(wdata[15:0], 16, rx);
      check_val("err_miso1", 32'(rx), 32'd0);
    end else if (!cmd[15]) begin
      mdl_err = 1'b0;
      xfer16(16'h0000, 16, rx);
      check_val("rd_hi", 32'(rx), 32'(snap_v[31:16]));
      xfer16(16'h0000, 16, rx);
      check_val("rd_lo", 32'(rx), 32'(snap_v[15:0]));
`ifdef ENC_SPI_CHECK_EN
      xfer16(16'h0000, 16, rx);
      check_val("rd_chk", 32'(rx), 32'(snap_v[31:16] ^ snap_v[15:0]));
`endif
    end else begin
      mdl_err = 1'b0;
      xfer16(wdata[31:16], 16, rx);
      xfer16(wdata[15:0], 16, rx);
`ifdef ENC_SPI_CHECK_EN
      xfer16(chk_word, 16, rx);
      if (chk_word == (wdata[31:16] ^ wdata[15:0])) exp_ld = 1'b1;
      else mdl_err = 1'b1;
`else
      exp_ld = 1'b1;
`endif
    end
    sel_end();
    if (exp_ld) mdl_val = wdata;
    check_val("err_flag", 32'(err_flag), 32'(mdl_err));
    check_val("busy_lo", 32'(busy), 32'd0);
    check_val("ld_count", 32'(ld_cycles - ld0), exp_ld ? 32'd1 : 32'd0);
    check_val("preset_val", preset_val, mdl_val);
    if (exp_ld) begin
      check_val("ld_chan", 32'(ld_seen), 32'(1) << ch);
      check_val("ld_val", ld_val, wdata);
    end
  endtask

  function automatic logic [NCH*CW-1:0] rand_pos();
    logic [NCH*CW-1:0] p;
    for (int i = 0; i < NCH; i++) p[i*CW +: CW] = $urandom;
    return p;
  endfunction

  initial begin
    logic [15:0]       rx;
    logic [NCH*CW-1:0] pos;
    logic [31:0]       wd;
    logic [15:0]       cmd;
    logic [15:0]       chk;
    int                ld0;

    repeat (4) @(negedge osc);
    check_val("rst_miso", 32'(MISO), 32'd0);
    check_val("rst_pval", preset_val, 32'd0);
    check_val("rst_pld", 32'(preset_ld), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_err", 32'(err_flag), 32'd0);
    rst_n = 1'b1;
    repeat (8) @(negedge osc);
    check_val("post_rst_err", 32'(err_flag), 32'd0);

    // Directed read of ch1; the live counter moves after the select edge
    pos = '0;
    pos[1*CW +: CW] = 32'h1234_5678;
    pos_flat = pos;
    pos[1*CW +: CW] = 32'hCAFE_F00D;
    do_txn(16'h0001, 32'h0, 16'h0, pos);

    do_txn(16'h8002, 32'hDEAD_BEEF, 16'hDEAD ^ 16'hBEEF, pos_flat);

    // Invalid channel, then the sticky flag shows in the next status word and clears
    do_txn(16'h0003, 32'h5555_AAAA, 16'h0, pos_flat);
    do_txn(16'h0002, 32'h0, 16'h0, rand_pos());
    do_txn(16'h0000, 32'h0, 16'h0, rand_pos());

    // Write aborted 7 bits into the second data frame
    ld0 = ld_cycles;
    sel_begin();
    xfer16(16'h8001, 16, rx);
    check_val("abort_status", 32'(rx), 32'(16'hE300 | {15'd0, mdl_err}));
    xfer16(16'hDEAD, 16, rx);
    xfer16(16'hBEEF, 7, rx);
    sel_end();
    mdl_err = 1'b1;
    check_val("abort_err", 32'(err_flag), 32'd1);
    check_val("abort_ld", 32'(ld_cycles - ld0), 32'd0);
    check_val("abort_pval", preset_val, mdl_val);
    check_val("abort_busy", 32'(busy), 32'd0);
    do_txn(16'h0001, 32'h0, 16'h0, rand_pos());

    // Reset in the middle of the high data frame of a write
    ld0 = ld_cycles;
    sel_begin();
    xfer16(16'h8000, 16, rx);
    xfer16(16'hDEAD, 8, rx);
    @(negedge osc);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_miso", 32'(MISO), 32'd0);
    check_val("mid_rst_pval", preset_val, 32'd0);
    check_val("mid_rst_pld", 32'(preset_ld), 32'd0);
    check_val("mid_rst_busy", 32'(busy), 32'd0);
    check_val("mid_rst_err", 32'(err_flag), 32'd0);
    mdl_err = 1'b0;
    mdl_val = '0;
    repeat (3) @(negedge osc);
    rst_n = 1'b1;
    xfer16(16'hBEEF, 16, rx);
    check_val("ignored_miso", 32'(rx), 32'd0);
    sel_end();
    check_val("ignored_ld", 32'(ld_cycles - ld0), 32'd0);
    check_val("ignored_err", 32'(err_flag), 32'd0);
    do_txn(16'h8002, 32'hDEAD_BEEF, 16'hDEAD ^ 16'hBEEF, rand_pos());

`ifdef ENC_SPI_CHECK_EN
    do_txn(16'h8001, 32'hDEAD_BEEF, 16'h0000, rand_pos());
`endif

    for (int n = 0; n < 20; n++) begin
      pos_flat = rand_pos();
      cmd = {1'($urandom_range(0, 1)), 13'($urandom), 2'($urandom_range(0, 3))};
      wd  = $urandom;
      chk = wd[31:16] ^ wd[15:0];
      if ($urandom_range(0, 3) == 0) chk = chk ^ (16'd1 << $urandom_range(0, 15));
      do_txn(cmd, wd, chk, rand_pos());
    end

    check_val("ld_onehot", 32'(ld_bad), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
